// File: rtl/pwm_capture.sv
// pwm_capture: measures period (rise to rise) and high time (rise to fall) of
// an asynchronous PWM input, counted in pwm_clk cycles.
//
// Ports:
//   pwm_clk     sole clock, rising edge
//   pwm_rst_n   asynchronous active-low reset
//   cap_en      capture enable (synchronous to pwm_clk)
//   pwm_in      measured waveform (asynchronous, synchronized internally)
//   period_val  last complete period in cycles
//   high_val    high time of that same period in cycles
//   cap_valid   one-cycle pulse when period_val/high_val update
//   cap_ovf     sticky: counter saturated before the expected edge
module pwm_capture #(
  parameter int unsigned CNT_LENGTH = 16
) (
  input  logic                  pwm_clk,
  input  logic                  pwm_rst_n,
  input  logic                  cap_en,
  input  logic                  pwm_in,
  output logic [CNT_LENGTH-1:0] period_val,
  output logic [CNT_LENGTH-1:0] high_val,
  output logic                  cap_valid,
  output logic                  cap_ovf
);

  localparam logic [CNT_LENGTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_LENGTH-1:0] CNT_ONE = CNT_LENGTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_LENGTH-1:0]   cnt_q, cnt_d;
  logic [CNT_LENGTH-1:0]   high_tmp_q, high_tmp_d;
  logic [CNT_LENGTH-1:0]   period_q, period_d;
  logic [CNT_LENGTH-1:0]   high_q, high_d;
  logic                    valid_q, valid_d;
  logic                    ovf_q, ovf_d;
  logic                    sync1_q, sync2_q, hist_q;
  logic                    rise, fall;
  logic                    cnt_sat;

  // Two-flop synchronizer plus history flop for edge detection.
  always_ff @(posedge pwm_clk or negedge pwm_rst_n) begin
    if (!pwm_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  assign rise    = sync2_q & ~hist_q;
  assign fall    = ~sync2_q & hist_q;
  assign cnt_sat = (cnt_q == CNT_MAX);

  // State and measurement registers.
  always_ff @(posedge pwm_clk or negedge pwm_rst_n) begin
    if (!pwm_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      high_tmp_q <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      high_tmp_q <= high_tmp_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
    end
  end

  // Next-state and datapath control.
  // A saturated counter wins over a coincident edge: the period it would end
  // is at least 2^CNT_LENGTH cycles and cannot be represented.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_tmp_d = high_tmp_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    ovf_d      = ovf_q;

    if (!cap_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end
        ARM: begin
          cnt_d = '0;
          if (rise) begin
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (cnt_sat) begin
            ovf_d   = 1'b1;
            cnt_d   = '0;
            state_d = ARM;
          end else if (fall) begin
            high_tmp_d = cnt_q + CNT_ONE;
            cnt_d      = cnt_q + CNT_ONE;
            state_d    = LOW;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        LOW: begin
          if (cnt_sat) begin
            ovf_d   = 1'b1;
            cnt_d   = '0;
            state_d = ARM;
          end else if (rise) begin
            period_d = cnt_q + CNT_ONE;
            high_d   = high_tmp_q;
            valid_d  = 1'b1;
            cnt_d    = '0;
            state_d  = HIGH;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign period_val = period_q;
  assign high_val   = high_q;
  assign cap_valid  = valid_q;
  assign cap_ovf    = ovf_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes expected results at each
// completing rise; a monitor pops and compares on every cap_valid pulse.
module tb_pwm_capture;

  localparam int unsigned CW = 12;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cap_en = 1'b0;
  logic          pwm_in = 1'b0;
  logic [CW-1:0] period_val, high_val;
  logic          cap_valid, cap_ovf;

  pwm_capture #(.CNT_LENGTH(CW)) dut (
    .pwm_clk   (clk),
    .pwm_rst_n (rst_n),
    .cap_en    (cap_en),
    .pwm_in    (pwm_in),
    .period_val(period_val),
    .high_val  (high_val),
    .cap_valid (cap_valid),
    .cap_ovf   (cap_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int p;
    int h;
    int c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   prev_p, prev_h;
  bit   have_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cap_valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && cap_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got cap_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("period_val", int'(period_val), e.p);
        chk("high_val", int'(high_val), e.h);
        chk("valid_latency_cycle", cyc, e.c);
        chk("high_lt_period", int'(high_val < period_val), 1);
      end
    end
  end

  // Drive a rise; if a period has just completed, the result is expected
  // three edges later.
  task automatic do_rise();
    pwm_in = 1'b1;
    if (have_prev) begin
      exp_t e;
      e.p = prev_p;
      e.h = prev_h;
      e.c = cyc + 3;
      q.push_back(e);
    end
  endtask

  task automatic period(input int hi, input int lo);
    do_rise();
    repeat (hi) @(negedge clk);
    pwm_in = 1'b0;
    repeat (lo) @(negedge clk);
    prev_p = hi + lo;
    prev_h = hi;
    have_prev = 1'b1;
  endtask

  task automatic start_capture();
    pwm_in = 1'b0;
    have_prev = 1'b0;
    cap_en = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Final rise closes the last period, then let the result drain and stop.
  task automatic finish_capture(input string name);
    do_rise();
    have_prev = 1'b0;
    repeat (6) @(negedge clk);
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    chk(name, q.size(), 0);
    cap_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1;
    chk("rst_period", int'(period_val), 0);
    chk("rst_high", int'(high_val), 0);
    chk("rst_valid", int'(cap_valid), 0);
    chk("rst_ovf", int'(cap_ovf), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 500/500: first result at second rise + 3, then one per period.
    start_capture();
    repeat (4) period(500, 500);
    finish_capture("drain_500_500");
    chk("hold_period_idle", int'(period_val), 1000);
    chk("hold_high_idle", int'(high_val), 500);

    // Duty change at a rise: 300/700 then 600/400.
    start_capture();
    repeat (3) period(300, 700);
    repeat (3) period(600, 400);
    finish_capture("drain_duty_change");

    // Minimum waveform 1/1.
    start_capture();
    repeat (10) period(1, 1);
    finish_capture("drain_1_1");

    // Held high after one rise: overflow on the exact boundary edge.
    start_capture();
    do_rise();
    begin
      int n;
      n = cyc;
      repeat (CMAX + 3) @(negedge clk);
      chk("ovf_hi_before_boundary", int'(cap_ovf), 0);
      @(negedge clk);
      chk("ovf_hi_at_boundary", int'(cap_ovf), 1);
      chk("ovf_hi_cycle", cyc - n, CMAX + 4);
    end
    pwm_in = 1'b0;
    @(negedge clk);
    cap_en = 1'b0;
    @(negedge clk);
    chk("ovf_cleared_by_en", int'(cap_ovf), 0);
    @(negedge clk);

    // Held low after one rise: overflow, then a later valid keeps it sticky.
    start_capture();
    do_rise();
    repeat (10) @(negedge clk);
    pwm_in = 1'b0;
    begin
      int k;
      k = 0;
      while (!cap_ovf && k < CMAX + 100) begin
        @(negedge clk);
        k++;
      end
      chk("ovf_lo_set", int'(cap_ovf), 1);
    end
    chk("ovf_lo_no_valid", q.size(), 0);
    repeat (2) period(200, 300);
    finish_capture("drain_after_ovf");
    chk("ovf_cleared_after", int'(cap_ovf), 0);
    cap_en = 1'b1;
    repeat (4) @(negedge clk);
    cap_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-HIGH with 1000/500 held.
    start_capture();
    repeat (2) period(500, 500);
    do_rise();
    have_prev = 1'b0;
    repeat (100) @(negedge clk);
    chk("pre_rst_period", int'(period_val), 1000);
    chk("pre_rst_high", int'(high_val), 500);
    #2;
    rst_n = 1'b0;
    pwm_in = 1'b0;
    #1;
    chk("async_rst_period", int'(period_val), 0);
    chk("async_rst_high", int'(high_val), 0);
    chk("async_rst_valid", int'(cap_valid), 0);
    chk("async_rst_ovf", int'(cap_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    repeat (2) period(400, 100);
    finish_capture("drain_after_rst");

    // cap_en dropped 10 cycles mid-LOW: partial period abandoned.
    start_capture();
    period(500, 500);
    do_rise();
    repeat (500) @(negedge clk);
    pwm_in = 1'b0;
    repeat (200) @(negedge clk);
    cap_en = 1'b0;
    have_prev = 1'b0;
    repeat (10) @(negedge clk);
    chk("drop_hold_period", int'(period_val), 1000);
    chk("drop_hold_high", int'(high_val), 500);
    cap_en = 1'b1;
    repeat (290) @(negedge clk);
    chk("drop_no_valid", q.size(), 0);
    repeat (2) period(250, 750);
    finish_capture("drain_after_drop");

    chk("final_queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout: got no completion expected finish before 2000000");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
